// File: rtl/cpu_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_mon_pkg
//  Description : Shared types and constants for the CPU run monitor: the
//                controller state encoding and the PC history depth.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_mon_pkg;

    // Controller states of the run monitor.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

    // Number of distinct PCs retained in the optional history.
    localparam int c_HIST_DEPTH = 4;

endpackage : cpu_mon_pkg
`default_nettype wire

// File: rtl/pc_history_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pc_history_buf
//  Description : Shift register holding the last c_HIST_DEPTH program
//                counters pushed into it. Newest entry sits at [DW-1:0].
//  Revision    : 1.0  initial release
//
//  Ports
//    clk      in   clock, rising edge
//    rst      in   synchronous active-high reset, clears all entries
//    i_clear  in   synchronous clear (start of a new run)
//    i_shift  in   push i_pc as newest entry
//    i_pc     in   DW   value to push
//    o_hist   out  c_HIST_DEPTH*DW   packed history, newest at [DW-1:0]
// ============================================================================
module pc_history_buf
    import cpu_mon_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_shift,
    input  logic [DW-1:0]              i_pc,
    output logic [c_HIST_DEPTH*DW-1:0] o_hist
);

    logic [c_HIST_DEPTH*DW-1:0] r_hist;

    // Older entries move toward the high end; the oldest falls off the top.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= {r_hist[(c_HIST_DEPTH-1)*DW-1:0], i_pc};
        end
    end

    assign o_hist = r_hist;

endmodule : pc_history_buf
`default_nettype wire

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_run_monitor
//  Description : Watches a CPU run started by a one-cycle start pulse. The
//                run ends when the PC has stayed unchanged for STALL_CYCLES
//                consecutive compares (halt) or after MAX_CYCLES clocks
//                (timeout). One clock later the watched channels are compared
//                against their expected values and the result is latched.
//                Halt wins over timeout when both occur in the same clock.
//  Revision    : 1.0  initial release
//
//  Optional feature
//    MON_PC_HISTORY_EN  defined   : keep the last four distinct PCs seen
//                                   during RUN on hist_pc
//                       undefined : hist_pc is tied to zero, no storage
//
//  Ports
//    clk          in   clock, rising edge
//    reset        in   synchronous active-high reset, aborts any run
//    start        in   one-cycle pulse, accepted in IDLE and DONE only
//    debug_pc     in   DW        current CPU program counter
//    watch_vals   in   NCH*DW    observed values, channel i at [i*DW +: DW]
//    exp_vals     in   NCH*DW    expected values, same packing
//    done         out  run finished, results valid
//    pass         out  every channel matched and no timeout
//    timeout      out  run ended by MAX_CYCLES rather than by halt
//    fail_mask    out  NCH       bit i set when channel i mismatched
//    cycle_count  out  clocks spent in RUN (saturates at MAX_CYCLES)
//    hist_pc      out  4*DW      last four distinct PCs, newest at [DW-1:0]
// ============================================================================
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int NCH          = 2,
    parameter int DW           = 32,
    parameter int MAX_CYCLES   = 50,
    parameter int STALL_CYCLES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [DW-1:0]                     debug_pc,
    input  logic [NCH*DW-1:0]                 watch_vals,
    input  logic [NCH*DW-1:0]                 exp_vals,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [NCH-1:0]                    fail_mask,
    output logic [$clog2(MAX_CYCLES+1)-1:0]   cycle_count,
    output logic [c_HIST_DEPTH*DW-1:0]        hist_pc
);

    localparam int             c_CW        = $clog2(MAX_CYCLES + 1);
    localparam logic [c_CW-1:0] c_cnt_max  = c_CW'(MAX_CYCLES);
    localparam logic [c_CW-1:0] c_cnt_last = c_CW'(MAX_CYCLES - 1);
    localparam logic [c_CW-1:0] c_cnt_one  = c_CW'(1);
    localparam logic [3:0]      c_stall_lim = 4'(STALL_CYCLES);

    mon_state_t        r_state;
    mon_state_t        w_state_nxt;
    logic              w_start_run;
    logic              w_leave_run;
    logic              w_halt;
    logic              w_tmo_hit;

    logic [DW-1:0]     r_prev_pc;
    logic [3:0]        r_stall_cnt;
    logic [c_CW-1:0]   r_cycle_cnt;
    logic [NCH-1:0]    r_fail_mask;
    logic              r_timeout;
    logic              r_done;
    logic              r_pass;
    logic [NCH-1:0]    w_mismatch;
    logic              w_pc_same;

    // ------------------------------------------------------------------
    // Per-channel comparison, sampled only in CHECK.
    // ------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_cmp
            assign w_mismatch[g] = (watch_vals[g*DW +: DW] != exp_vals[g*DW +: DW]);
        end
    endgenerate

    assign w_pc_same = (debug_pc == r_prev_pc);

    // Both end conditions look at registered counts, so the halt becomes
    // visible the clock after the final equal compare; CHECK then adds one
    // more clock, giving the fixed two-clock halt-to-done latency.
    assign w_halt    = (r_stall_cnt == c_stall_lim);
    assign w_tmo_hit = (r_cycle_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        w_leave_run = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_halt || w_tmo_hit) begin
                    w_state_nxt = ST_CHECK;
                    w_leave_run = 1'b1;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_start_run = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_pc   <= '0;
            r_stall_cnt <= '0;
            r_cycle_cnt <= '0;
            r_fail_mask <= '0;
            r_timeout   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            // prev_pc follows the PC every clock, so the first RUN compare
            // is against the PC seen in the cycle that carried start.
            r_prev_pc <= debug_pc;

            if (w_start_run) begin
                r_stall_cnt <= '0;
                r_cycle_cnt <= '0;
                r_fail_mask <= '0;
                r_timeout   <= 1'b0;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (r_cycle_cnt != c_cnt_max) begin
                    r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
                end
                if (w_pc_same) begin
                    if (r_stall_cnt != 4'hF) begin
                        r_stall_cnt <= r_stall_cnt + 4'd1;
                    end
                end else begin
                    r_stall_cnt <= '0;
                end
                if (w_leave_run) begin
                    r_timeout <= !w_halt;
                end
            end else if (r_state == ST_CHECK) begin
                r_fail_mask <= w_mismatch;
                r_pass      <= (w_mismatch == '0) && !r_timeout;
                r_done      <= 1'b1;
            end
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign fail_mask   = r_fail_mask;
    assign cycle_count = r_cycle_cnt;

    // ------------------------------------------------------------------
    // Optional PC history
    // ------------------------------------------------------------------
`ifdef MON_PC_HISTORY_EN
    logic w_hist_push;

    assign w_hist_push = (r_state == ST_RUN) && !w_pc_same;

    pc_history_buf #(
        .DW (DW)
    ) u_pc_history_buf (
        .clk     (clk),
        .rst     (reset),
        .i_clear (w_start_run),
        .i_shift (w_hist_push),
        .i_pc    (debug_pc),
        .o_hist  (hist_pc)
    );
`else
    assign hist_pc = '0;
`endif

endmodule : cpu_run_monitor
`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_run_monitor
//  Description : Self-checking bench for cpu_run_monitor. Directed runs for
//                the documented scenarios plus randomized runs, all checked
//                against a window-based reference model of the run rules.
//                Honours MON_PC_HISTORY_EN for the expected hist_pc.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_run_monitor;

    localparam int NCH   = 2;
    localparam int DW    = 32;
    localparam int MAXC  = 50;
    localparam int STALL = 4;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int SEQ_N = 72;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [DW-1:0]       debug_pc;
    logic [NCH*DW-1:0]   watch_vals;
    logic [NCH*DW-1:0]   exp_vals;
    logic                done;
    logic                pass;
    logic                timeout;
    logic [NCH-1:0]      fail_mask;
    logic [CW-1:0]       cycle_count;
    logic [4*DW-1:0]     hist_pc;

    int n_total = 0;
    int n_bad   = 0;

    // seq[0] is the PC presented with start; seq[t+1] is the PC during
    // RUN cycle t.
    logic [DW-1:0] seq [SEQ_N];

    int              m_end;
    logic            m_tmo;
    logic [NCH-1:0]  m_mask;
    logic            m_pass;
    int              m_cnt;
    logic [4*DW-1:0] m_hist;

    cpu_run_monitor #(
        .NCH          (NCH),
        .DW           (DW),
        .MAX_CYCLES   (MAXC),
        .STALL_CYCLES (STALL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .debug_pc    (debug_pc),
        .watch_vals  (watch_vals),
        .exp_vals    (exp_vals),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_mask   (fail_mask),
        .cycle_count (cycle_count),
        .hist_pc     (hist_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a halt is a window of STALL+1 identical PCs; it is
    // recognised in the RUN cycle indexed by the window's last element.
    function automatic void model_run();
        int            halt_at;
        logic [DW-1:0] changes [$];
        halt_at = -1;
        for (int c = STALL; c < SEQ_N && halt_at < 0; c++) begin
            bit same;
            same = 1'b1;
            for (int j = c - STALL; j < c; j++)
                if (seq[j] != seq[j+1]) same = 1'b0;
            if (same) halt_at = c;
        end
        if (halt_at >= 0 && halt_at <= MAXC - 1) begin
            m_end = halt_at;
            m_tmo = 1'b0;
        end else begin
            m_end = MAXC - 1;
            m_tmo = 1'b1;
        end
        m_cnt = (m_end + 1 < MAXC) ? m_end + 1 : MAXC;
        for (int t = 0; t <= m_end; t++)
            if (seq[t+1] != seq[t]) changes.push_back(seq[t+1]);
        m_hist = '0;
`ifdef MON_PC_HISTORY_EN
        for (int i = 0; i < 4; i++)
            if (changes.size() > i) m_hist[i*DW +: DW] = changes[changes.size()-1-i];
`endif
        for (int i = 0; i < NCH; i++)
            m_mask[i] = (watch_vals[i*DW +: DW] != exp_vals[i*DW +: DW]);
        m_pass = (m_mask == '0) && !m_tmo;
    endfunction

    task automatic fill_ramp(input int hold_from);
        seq[0] = 32'hFFFF_FFF0;
        for (int i = 1; i < SEQ_N; i++)
            seq[i] = 32'(4 * (((i < hold_from) ? i : hold_from) - 1));
    endtask

    task automatic do_run(input string tag, input bit inject);
        int found;
        int inj_k;
        model_run();
        inj_k = inject ? $urandom_range(0, m_end + 1) : -1;
        start    = 1'b1;
        debug_pc = seq[0];
        tick();
        found = -1;
        for (int k = 0; k < 70 && found < 0; k++) begin
            debug_pc = seq[(k + 1 < SEQ_N) ? k + 1 : SEQ_N - 1];
            start    = (k == inj_k);
            tick();
            if (done) found = k;
        end
        start = 1'b0;
        chk({tag, ".latency"},  found,       m_end + 1);
        chk({tag, ".timeout"},  timeout,     m_tmo);
        chk({tag, ".pass"},     pass,        m_pass);
        chk({tag, ".failmask"}, fail_mask,   m_mask);
        chk({tag, ".cycles"},   cycle_count, m_cnt);
        chk({tag, ".hist"},     hist_pc,     m_hist);
        // Results and history must stay frozen while sitting in DONE.
        for (int k = 0; k < 2; k++) begin
            debug_pc = $urandom;
            tick();
        end
        chk({tag, ".hold_done"}, done,        1'b1);
        chk({tag, ".hold_mask"}, fail_mask,   m_mask);
        chk({tag, ".hold_cyc"},  cycle_count, m_cnt);
        chk({tag, ".hold_hist"}, hist_pc,     m_hist);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        debug_pc   = '0;
        watch_vals = '0;
        exp_vals   = '0;
        repeat (3) tick();
        chk("rst.done",  done,        1'b0);
        chk("rst.pass",  pass,        1'b0);
        chk("rst.tmo",   timeout,     1'b0);
        chk("rst.mask",  fail_mask,   '0);
        chk("rst.cyc",   cycle_count, '0);
        chk("rst.hist",  hist_pc,     '0);
        reset = 1'b0;
        tick();

        // Ramp to 0x20 then hold, all channels matching.
        fill_ramp(9);
        watch_vals = {32'd15, 32'd15};
        exp_vals   = {32'd15, 32'd15};
        do_run("halt_match", 1'b0);
        chk("halt_match.pass_c", pass,        1'b1);
        chk("halt_match.cyc_c",  cycle_count, 14);

        // Same run, channel 1 differs (restart from DONE).
        watch_vals = {32'd14, 32'd15};
        do_run("halt_ch1", 1'b0);
        chk("halt_ch1.mask_c", fail_mask, 2'b10);
        chk("halt_ch1.pass_c", pass,      1'b0);

        // PC never holds: timeout with matching channels.
        watch_vals = {32'd15, 32'd15};
        fill_ramp(SEQ_N);
        do_run("timeout", 1'b0);
        chk("timeout.tmo_c",  timeout,     1'b1);
        chk("timeout.pass_c", pass,        1'b0);
        chk("timeout.cyc_c",  cycle_count, MAXC);

        // Reset in the middle of a run.
        fill_ramp(SEQ_N);
        start    = 1'b1;
        debug_pc = seq[0];
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            debug_pc = seq[k+1];
            tick();
        end
        chk("midrst.cyc_before", cycle_count, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.done", done,        1'b0);
        chk("midrst.cyc",  cycle_count, '0);
        chk("midrst.mask", fail_mask,   '0);
        chk("midrst.hist", hist_pc,     '0);
        fill_ramp(9);
        do_run("after_rst", 1'b0);

        // Reset and start together: must stay idle.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            debug_pc = 32'(k * 4);
            tick();
        end
        chk("rst_start.cyc",  cycle_count, '0);
        chk("rst_start.done", done,        1'b0);

        // Halt recognised in the very cycle the timeout limit is reached.
        fill_ramp(45);
        do_run("halt_at_limit", 1'b0);
        chk("halt_at_limit.tmo_c", timeout, 1'b0);
        chk("halt_at_limit.pass_c", pass,   1'b1);
        // One clock later the timeout wins.
        fill_ramp(46);
        do_run("halt_past_limit", 1'b0);
        chk("halt_past_limit.tmo_c", timeout, 1'b1);

        // History contents for a short ramp.
        fill_ramp(5);
        do_run("hist", 1'b0);
`ifdef MON_PC_HISTORY_EN
        chk("hist.direct", hist_pc, {32'h4, 32'h8, 32'hC, 32'h10});
`else
        chk("hist.direct", hist_pc, '0);
`endif

        // Randomized runs, some with stray start pulses during RUN/CHECK.
        for (int r = 0; r < 40; r++) begin
            int p;
            p = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(30, 75);
            seq[0] = $urandom;
            for (int i = 1; i < SEQ_N; i++)
                seq[i] = ($urandom_range(0, 99) < p) ? seq[i-1] : $urandom;
            for (int c = 0; c < NCH; c++) begin
                logic [DW-1:0] w;
                w = $urandom;
                watch_vals[c*DW +: DW] = w;
                exp_vals[c*DW +: DW]   = $urandom_range(0, 1) ? w : (w ^ (32'h1 << $urandom_range(0, 31)));
            end
            do_run($sformatf("rand%0d", r), $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_cpu_run_monitor
`default_nettype wire

// File: doc/cpu_run_monitor.md
CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 SHALL have parameter NCH, default 2, number of watched debug channels (1..8).
REQ-002 SHALL have parameter DW, default 32, width of PC and each channel.
REQ-003 SHALL have parameter MAX_CYCLES, default 50, run timeout in clocks.
REQ-004 SHALL have parameter STALL_CYCLES, default 4, consecutive equal-PC compares that declare halt (2..15).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  one-cycle pulse that begins a monitored run.
REQ-008 SHALL have port debug_pc  in  DW  current CPU program counter.
REQ-009 SHALL have port watch_vals  in  NCH*DW  observed values; channel i at bits [i*DW +: DW].
REQ-010 SHALL have port exp_vals  in  NCH*DW  expected values, same packing.
REQ-011 SHALL have port done  out  1  run finished and results valid.
REQ-012 SHALL have port pass  out  1  all channels matched and no timeout.
REQ-013 SHALL have port timeout  out  1  run ended by MAX_CYCLES, not by halt.
REQ-014 SHALL have port fail_mask  out  NCH  bit i set when channel i mismatched.
REQ-015 SHALL have port cycle_count  out  $clog2(MAX_CYCLES+1)  clocks spent in RUN.
REQ-016 SHALL have port hist_pc  out  4*DW  last four distinct PCs, newest at [DW-1:0].

Function
REQ-017 SHALL implement FSM states IDLE, RUN, CHECK, DONE.
REQ-018 IDLE: start=1 SHALL move to RUN next cycle, clearing cycle_count, stall counter, fail_mask, timeout, done, pass.
REQ-019 RUN: cycle_count SHALL increment by 1 per clock and saturate at MAX_CYCLES.
REQ-020 RUN: a prev_pc register SHALL capture debug_pc each clock; stall counter increments when debug_pc==prev_pc, else clears to 0.
REQ-021 RUN: stall counter reaching STALL_CYCLES SHALL move to CHECK with timeout=0.
REQ-022 RUN: cycle_count reaching MAX_CYCLES-1 without halt SHALL move to CHECK with timeout=1.
REQ-023 Halt and timeout in the same cycle SHALL resolve as halt (timeout=0).
REQ-024 CHECK (exactly one cycle): fail_mask[i] SHALL be registered as watch_vals channel i != exp_vals channel i; next state DONE.
REQ-025 DONE: done=1; pass=(fail_mask==0)&&!timeout; all results held stable.
REQ-026 start in DONE SHALL restart as in REQ-018; start in RUN or CHECK SHALL be ignored.
REQ-027 Latency from halt condition to done=1 SHALL be exactly 2 clocks.

Reset
REQ-028 reset SHALL force IDLE and zero done, pass, timeout, fail_mask, cycle_count, hist_pc, stall counter, prev_pc.
REQ-029 reset asserted in any state, including mid-RUN, SHALL abort the run with no result reported.
REQ-030 reset and start asserted together SHALL leave the block in IDLE.

Configuration
REQ-031 Macro MON_PC_HISTORY_EN defined: during RUN, each clock where debug_pc!=prev_pc SHALL shift debug_pc into a 4-entry history, frozen outside RUN and cleared on start.
REQ-032 Macro MON_PC_HISTORY_EN undefined: hist_pc SHALL be constant zero, no history storage synthesised; all other behaviour identical.

Structure
REQ-033 Package cpu_mon_pkg SHALL hold the FSM state typedef and the history depth constant (4).
REQ-034 History storage SHALL be a sub-module pc_history_buf, instantiated only under MON_PC_HISTORY_EN.

Verification
REQ-035 PC advances 0,4,8,...,0x20 then holds; watch={15,15}, exp={15,15} -> done 2 clocks after 4th equal compare, pass=1, timeout=0, fail_mask=00.
REQ-036 Same run, watch ch1=14 -> done=1, pass=0, fail_mask=10, timeout=0.
REQ-037 PC increments every clock, MAX_CYCLES=50 -> CHECK after cycle_count=49, done with timeout=1, pass=0 even with matching channels.
REQ-038 reset pulsed at cycle 10 of RUN -> IDLE, done=0, cycle_count=0; later start gives a fresh clean run.
REQ-039 Halt reached on the same cycle as timeout limit -> timeout=0, pass follows compare only.
REQ-040 MON_PC_HISTORY_EN defined, PCs 0x0,0x4,0x8,0xC,0x10 then hold -> hist_pc = {0x4,0x8,0xC,0x10} oldest-to-newest; undefined -> hist_pc=0.
